// File: rtl/mox125_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mox125_bus_arbiter
//
// Two-master arbiter in front of one shared external memory bus (Wishbone-like
// classic cycles). Master 0 is the read-only instruction-cache fill port;
// master 1 is the data port.
//
// Handshake: a master owns the bus for as long as it holds cyc high once
// granted. Each beat is offered with stb and completes in the cycle where the
// slave returns ack; cyc may stay high across strobe gaps. Owner changes always
// pass through IDLE, so there is no preemption. If the owner strobes for
// TIMEOUT cycles and no ack comes, the owner gets a one-cycle err. The arbiter
// then parks in DRAIN until that owner drops cyc.
//
// Ports:
//   clk_i, rst_n_i           clock, asynchronous active-low reset
//   m0_adr/sel/cyc/stb_i     master 0 request (read only)
//   m0_dat/ack/err_o         master 0 response
//   m1_adr/dat/we/sel/cyc/stb_i  master 1 request
//   m1_dat/ack/err_o         master 1 response
//   s_adr/dat/we/sel/cyc/stb_o   shared bus request
//   s_dat_i, s_ack_i         shared bus response
//   gnt_o                    one-hot owner (bit0 = m0, bit1 = m1)
//   state_o                  FSM state (IDLE=0, GNT0=1, GNT1=2, DRAIN=3)
// -----------------------------------------------------------------------------
module mox125_bus_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] m0_adr_i,
  input  logic [1:0]  m0_sel_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  output logic [15:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic [31:0] m1_adr_i,
  input  logic [15:0] m1_dat_i,
  input  logic        m1_we_i,
  input  logic [1:0]  m1_sel_i,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  output logic [15:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] s_adr_o,
  output logic [15:0] s_dat_o,
  output logic        s_we_o,
  output logic [1:0]  s_sel_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  input  logic [15:0] s_dat_i,
  input  logic        s_ack_i,
  output logic [1:0]  gnt_o,
  output logic [1:0]  state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT0  = 2'd1,
    GNT1  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic [7:0] TIMEOUT_V = 8'(TIMEOUT);

  state_t     state;
  logic       last_gnt;
  logic [7:0] stall_cnt;

  logic       in_gnt;
  logic       owner_cyc;
  logic       owner_stb;
  logic       timeout_hit;

  // last_gnt always names the current owner in GNTx, and it still names the
  // erroring owner in DRAIN, so one mux serves both states.
  assign in_gnt      = (state == GNT0) || (state == GNT1);
  assign owner_cyc   = last_gnt ? m1_cyc_i : m0_cyc_i;
  assign owner_stb   = last_gnt ? m1_stb_i : m0_stb_i;
  // An ack in the same cycle the limit is reached wins over the error.
  assign timeout_hit = in_gnt && (stall_cnt == TIMEOUT_V) && !s_ack_i;

  assign state_o  = state;
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= IDLE;
      last_gnt  <= 1'b0;
      stall_cnt <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          stall_cnt <= 8'd0;
          // On a tie, grant the master that did not have the bus last.
          if (m1_cyc_i && (!m0_cyc_i || !last_gnt)) begin
            state    <= GNT1;
            last_gnt <= 1'b1;
          end else if (m0_cyc_i) begin
            state    <= GNT0;
            last_gnt <= 1'b0;
          end
        end
        GNT0, GNT1: begin
          if (timeout_hit) begin
            state     <= DRAIN;
            stall_cnt <= 8'd0;
          end else if (!owner_cyc) begin
            state     <= IDLE;
            stall_cnt <= 8'd0;
          end else if (s_ack_i || !owner_stb) begin
            stall_cnt <= 8'd0;
          end else if (stall_cnt != 8'hFF) begin
            stall_cnt <= stall_cnt + 8'd1;
          end
        end
        DRAIN: begin
          stall_cnt <= 8'd0;
          if (!owner_cyc) begin
            state <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          stall_cnt <= 8'd0;
        end
      endcase
    end
  end

  // Bus steering and responses are decoded from the registered state, so a
  // reset clears them immediately without waiting for a clock edge.
  always_comb begin
    s_adr_o  = 32'd0;
    s_dat_o  = 16'd0;
    s_we_o   = 1'b0;
    s_sel_o  = 2'b00;
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    gnt_o    = 2'b00;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    case (state)
      GNT0: begin
        s_adr_o  = m0_adr_i;
        s_sel_o  = m0_sel_i;
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i;
        gnt_o    = 2'b01;
        m0_ack_o = s_ack_i && m0_stb_i;
        m0_err_o = timeout_hit;
      end
      GNT1: begin
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_we_o   = m1_we_i;
        s_sel_o  = m1_sel_i;
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i;
        gnt_o    = 2'b10;
        m1_ack_o = s_ack_i && m1_stb_i;
        m1_err_o = timeout_hit;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_mox125_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mox125_bus_arbiter
//
// Bench for mox125_bus_arbiter with TIMEOUT=4. The slave model acks any strobe
// in the same cycle when slave_en is set. Its read data is the low address
// half XOR 16'h5A5A. force_ack injects a stray ack.
// Inputs change 1 time unit after a rising edge. Outputs are sampled 1 time
// unit later, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_mox125_bus_arbiter;

  logic        clk;
  logic        rst_n;
  logic [31:0] m0_adr;
  logic [1:0]  m0_sel;
  logic        m0_cyc;
  logic        m0_stb;
  logic [15:0] m0_dat;
  logic        m0_ack;
  logic        m0_err;
  logic [31:0] m1_adr;
  logic [15:0] m1_wdat;
  logic        m1_we;
  logic [1:0]  m1_sel;
  logic        m1_cyc;
  logic        m1_stb;
  logic [15:0] m1_dat;
  logic        m1_ack;
  logic        m1_err;
  logic [31:0] s_adr;
  logic [15:0] s_dat_o;
  logic        s_we;
  logic [1:0]  s_sel;
  logic        s_cyc;
  logic        s_stb;
  logic [15:0] s_dat_i;
  logic        s_ack;
  logic [1:0]  gnt;
  logic [1:0]  state_dbg;

  logic        slave_en;
  logic        force_ack;

  int checks   = 0;
  int failures = 0;

  // Scoreboard entries are {address, data}.
  logic [47:0] exp_q[$];
  logic [47:0] exp_v;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign s_ack   = force_ack | (slave_en & s_stb);
  assign s_dat_i = s_adr[15:0] ^ 16'h5A5A;

  mox125_bus_arbiter #(.TIMEOUT(4)) dut (
    .clk_i    (clk),
    .rst_n_i  (rst_n),
    .m0_adr_i (m0_adr),
    .m0_sel_i (m0_sel),
    .m0_cyc_i (m0_cyc),
    .m0_stb_i (m0_stb),
    .m0_dat_o (m0_dat),
    .m0_ack_o (m0_ack),
    .m0_err_o (m0_err),
    .m1_adr_i (m1_adr),
    .m1_dat_i (m1_wdat),
    .m1_we_i  (m1_we),
    .m1_sel_i (m1_sel),
    .m1_cyc_i (m1_cyc),
    .m1_stb_i (m1_stb),
    .m1_dat_o (m1_dat),
    .m1_ack_o (m1_ack),
    .m1_err_o (m1_err),
    .s_adr_o  (s_adr),
    .s_dat_o  (s_dat_o),
    .s_we_o   (s_we),
    .s_sel_o  (s_sel),
    .s_cyc_o  (s_cyc),
    .s_stb_o  (s_stb),
    .s_dat_i  (s_dat_i),
    .s_ack_i  (s_ack),
    .gnt_o    (gnt),
    .state_o  (state_dbg)
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_adr = 32'd0; m0_sel = 2'b00; m0_cyc = 1'b0; m0_stb = 1'b0;
    m1_adr = 32'd0; m1_wdat = 16'd0; m1_we = 1'b0; m1_sel = 2'b00;
    m1_cyc = 1'b0;  m1_stb = 1'b0;
    slave_en = 1'b0; force_ack = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    #3;
    checks++;
    if (gnt !== 2'b00) begin failures++; $display("FAIL reset_gnt: got %b want 00", gnt); end
    checks++;
    if (s_cyc !== 1'b0 || s_stb !== 1'b0 || s_adr !== 32'd0) begin
      failures++; $display("FAIL reset_bus: cyc=%b stb=%b adr=%h want 0", s_cyc, s_stb, s_adr);
    end
    checks++;
    if (state_dbg !== 2'd0) begin failures++; $display("FAIL reset_state: got %0d want 0", state_dbg); end
    force_ack = 1'b1;
    #1;
    checks++;
    if ({m0_ack, m0_err, m1_ack, m1_err} !== 4'b0000) begin
      failures++; $display("FAIL reset_resp: ack/err=%b want 0000", {m0_ack, m0_err, m1_ack, m1_err});
    end
    force_ack = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  // Tie straight after reset goes to m1; the hand-back to m0 passes through IDLE.
  task automatic test_tie_after_reset();
    m0_cyc = 1'b1; m1_cyc = 1'b1; m1_adr = 32'h0000_0400; m0_adr = 32'h0000_0800;
    #1;
    checks++;
    if (gnt !== 2'b00 || s_cyc !== 1'b0) begin
      failures++; $display("FAIL tie_idle: gnt=%b cyc=%b want 00/0", gnt, s_cyc);
    end
    tick();
    checks++;
    if (gnt !== 2'b10) begin failures++; $display("FAIL tie_gnt1: got %b want 10", gnt); end
    checks++;
    if (s_cyc !== 1'b1 || s_adr !== 32'h0000_0400) begin
      failures++; $display("FAIL tie_bus: cyc=%b adr=%h want 1/00000400", s_cyc, s_adr);
    end
    m1_cyc = 1'b0;
    #1;
    checks++;
    if (s_cyc !== 1'b0) begin failures++; $display("FAIL tie_cyc_follow: got %b want 0", s_cyc); end
    tick();
    checks++;
    if (gnt !== 2'b00 || state_dbg !== 2'd0) begin
      failures++; $display("FAIL tie_gap: gnt=%b state=%0d want 00/0", gnt, state_dbg);
    end
    tick();
    checks++;
    if (gnt !== 2'b01 || s_adr !== 32'h0000_0800) begin
      failures++; $display("FAIL tie_gnt0: gnt=%b adr=%h want 01/00000800", gnt, s_adr);
    end
    m0_cyc = 1'b0;
    tick();
  endtask

  // 16-beat fill by m0 with a strobe gap per beat while m1 waits.
  task automatic test_burst();
    int n;
    int beat_fail;
    int gap_fail;
    m0_cyc = 1'b1; m0_sel = 2'b11;
    tick();
    checks++;
    if (gnt !== 2'b01) begin failures++; $display("FAIL burst_grant: got %b want 01", gnt); end
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 32'h0000_0600; m1_we = 1'b0;
    slave_en = 1'b1;
    beat_fail = 0;
    gap_fail  = 0;
    for (int b = 0; b < 16; b++) begin
      m0_adr = 32'h0000_2000 + 32'(2 * b);
      m0_stb = 1'b1;
      exp_q.push_back({m0_adr, m0_adr[15:0] ^ 16'h5A5A});
      #1;
      n = 0;
      while (!m0_ack && n < 8) begin tick(); n++; end
      checks++;
      if (!m0_ack) begin
        failures++; $display("FAIL burst_ack_wait: beat %0d no ack within 8 cycles", b);
        void'(exp_q.pop_front());
      end else begin
        exp_v = exp_q.pop_front();
        if ({s_adr, m0_dat} !== exp_v) begin
          failures++; beat_fail++;
          $display("FAIL burst_beat: beat %0d got adr=%h dat=%h want adr=%h dat=%h",
                   b, s_adr, m0_dat, exp_v[47:16], exp_v[15:0]);
        end
      end
      checks++;
      if (gnt !== 2'b01 || m1_ack !== 1'b0) begin
        failures++; $display("FAIL burst_owner: beat %0d gnt=%b m1_ack=%b want 01/0", b, gnt, m1_ack);
      end
      tick();
      m0_stb = 1'b0;
      #1;
      checks++;
      if (s_stb !== 1'b0 || gnt !== 2'b01 || s_cyc !== 1'b1) begin
        failures++; gap_fail++;
        $display("FAIL burst_gap: beat %0d stb=%b gnt=%b cyc=%b want 0/01/1", b, s_stb, gnt, s_cyc);
      end
      tick();
    end
    m0_cyc = 1'b0;
    #1;
    tick();
    checks++;
    if (gnt !== 2'b00 || m1_ack !== 1'b0) begin
      failures++; $display("FAIL burst_release: gnt=%b m1_ack=%b want 00/0", gnt, m1_ack);
    end
    tick();
    checks++;
    if (gnt !== 2'b10) begin failures++; $display("FAIL burst_m1_grant: got %b want 10", gnt); end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL burst_queue: %0d left want 0", exp_q.size()); end
  endtask

  // m1 write while m0 strobes as a non-owner; m1 is already the owner here.
  task automatic test_write();
    m1_adr = 32'h0000_0100; m1_wdat = 16'hBEEF; m1_we = 1'b1; m1_sel = 2'b11; m1_stb = 1'b1;
    m0_cyc = 1'b1; m0_stb = 1'b1;
    exp_q.push_back({32'h0000_0100, 16'hBEEF});
    #1;
    exp_v = exp_q.pop_front();
    checks++;
    if ({s_adr, s_dat_o} !== exp_v || s_we !== 1'b1 || s_sel !== 2'b11) begin
      failures++; $display("FAIL write_bus: adr=%h dat=%h we=%b sel=%b want %h/%h/1/11",
                           s_adr, s_dat_o, s_we, s_sel, exp_v[47:16], exp_v[15:0]);
    end
    checks++;
    if (m1_ack !== 1'b1 || m0_ack !== 1'b0) begin
      failures++; $display("FAIL write_ack: m1_ack=%b m0_ack=%b want 1/0", m1_ack, m0_ack);
    end
    checks++;
    if (m1_dat !== s_dat_i || m0_dat !== s_dat_i) begin
      failures++; $display("FAIL read_data_path: m0=%h m1=%h want %h", m0_dat, m1_dat, s_dat_i);
    end
    slave_en = 1'b0;
    #1;
    checks++;
    if (m1_ack !== 1'b0) begin failures++; $display("FAIL write_ack_follow: got %b want 0", m1_ack); end
    tick();
    m1_stb = 1'b0; m1_cyc = 1'b0; m1_we = 1'b0; m0_stb = 1'b0; m0_cyc = 1'b0;
    tick();
  endtask

  // m1 strobes into a silent slave; err on the 5th stalled cycle, then DRAIN.
  task automatic test_timeout();
    int err_at;
    slave_en = 1'b0;
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 32'h0000_0300;
    tick();
    err_at = 0;
    for (int i = 1; i <= 10; i++) begin
      if (m1_err) begin err_at = i; break; end
      tick();
    end
    checks++;
    if (err_at != 5) begin failures++; $display("FAIL timeout_cycle: err at stall %0d want 5", err_at); end
    checks++;
    if (s_cyc !== 1'b1 || m0_err !== 1'b0) begin
      failures++; $display("FAIL timeout_owner: cyc=%b m0_err=%b want 1/0", s_cyc, m0_err);
    end
    tick();
    checks++;
    if (m1_err !== 1'b0) begin failures++; $display("FAIL timeout_pulse: err=%b want 0", m1_err); end
    checks++;
    if (s_cyc !== 1'b0 || s_stb !== 1'b0 || gnt !== 2'b00 || state_dbg !== 2'd3) begin
      failures++; $display("FAIL drain_bus: cyc=%b stb=%b gnt=%b state=%0d want 0/0/00/3",
                           s_cyc, s_stb, gnt, state_dbg);
    end
    force_ack = 1'b1;
    #1;
    checks++;
    if (m1_ack !== 1'b0 || m1_err !== 1'b0) begin
      failures++; $display("FAIL drain_stray_ack: ack=%b err=%b want 0/0", m1_ack, m1_err);
    end
    force_ack = 1'b0;
    tick();
    checks++;
    if (state_dbg !== 2'd3) begin failures++; $display("FAIL drain_hold: state=%0d want 3", state_dbg); end
    m1_cyc = 1'b0; m1_stb = 1'b0;
    tick();
    checks++;
    if (state_dbg !== 2'd0) begin failures++; $display("FAIL drain_exit: state=%0d want 0", state_dbg); end
  endtask

  // Ack arriving exactly on the timeout cycle counts as a normal ack.
  task automatic test_timeout_ack();
    slave_en = 1'b0;
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 32'h0000_0310;
    tick();
    for (int i = 0; i < 4; i++) tick();
    force_ack = 1'b1;
    #1;
    checks++;
    if (m1_err !== 1'b0 || m1_ack !== 1'b1) begin
      failures++; $display("FAIL timeout_ack_race: err=%b ack=%b want 0/1", m1_err, m1_ack);
    end
    tick();
    force_ack = 1'b0;
    #1;
    checks++;
    if (m1_err !== 1'b0 || state_dbg !== 2'd2) begin
      failures++; $display("FAIL timeout_ack_clear: err=%b state=%0d want 0/2", m1_err, state_dbg);
    end
    m1_cyc = 1'b0; m1_stb = 1'b0;
    tick();
  endtask

  // Asynchronous reset in the middle of an m0 burst.
  task automatic test_async_reset();
    slave_en = 1'b1;
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_sel = 2'b11; m0_adr = 32'h0000_2000;
    tick();
    checks++;
    if (gnt !== 2'b01) begin failures++; $display("FAIL arst_grant: got %b want 01", gnt); end
    m0_adr = 32'h0000_2002;
    tick();
    m1_cyc = 1'b1; m1_stb = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (s_cyc !== 1'b0 || s_stb !== 1'b0 || gnt !== 2'b00 || m0_ack !== 1'b0) begin
      failures++; $display("FAIL arst_immediate: cyc=%b stb=%b gnt=%b ack=%b want 0/0/00/0",
                           s_cyc, s_stb, gnt, m0_ack);
    end
    #2;
    rst_n = 1'b1;
    tick();
    checks++;
    if (gnt !== 2'b10) begin failures++; $display("FAIL arst_tie: got %b want 10", gnt); end
    idle_inputs();
    tick();
    tick();
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_tie_after_reset();
    test_burst();
    test_write();
    test_timeout();
    test_timeout_ack();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
